cplx_alu: RTL and testbench

- Sequential complex fixed-point ALU directly downstream of the register bank.
- Consumes the bank's registered outA/outB as two complex operands: high 32-bit word = real, low 32-bit word = imaginary, each signed Q(31-FRAC).FRAC.
- Produces a 64-bit result plus a one-cycle write strobe and destination index, so the controller can route them back to the bank's inA/regwen/selwreg.
- Multiplication is done iteratively through one shared 32x32 signed multiplier.

---
 rtl/cplx_alu_pkg.sv | 46 ++++
 rtl/cplx_alu_if.sv | 25 ++
 rtl/cplx_alu_sat.sv | 19 +
 rtl/cplx_alu.sv | 179 +++++++++++++++++
 tb/tb_cplx_alu.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cplx_alu_pkg.sv
// Shared constants, opcode/state encodings and the field saturation helper
// for the complex fixed-point ALU.
package cplx_pkg;

    localparam int unsigned W_DEF    = 32;
    localparam int unsigned FRAC_DEF = 16;
    localparam int unsigned ACC_W    = 2 * W_DEF + 2;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_CONJ = 3'b011;
    localparam logic [2:0] OP_NEG  = 3'b100;
    localparam logic [2:0] OP_MAG2 = 3'b101;
    localparam logic [2:0] OP_SWAP = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PROD = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    typedef struct packed {
        logic [W_DEF-1:0] val;
        logic             ovf;
    } sat_t;

    // A value fits in W bits only when every bit from the MSB down to bit W-1
    // is a copy of the sign; otherwise clamp toward the sign's bound.
    function automatic sat_t sat_w(input logic signed [ACC_W-1:0] x);
        sat_t r;
        logic [ACC_W-W_DEF:0] hi;
        hi = x[ACC_W-1:W_DEF-1];
        if (hi == '0 || hi == '1) begin
            r.val = x[W_DEF-1:0];
            r.ovf = 1'b0;
        end else if (x[ACC_W-1]) begin
            r.val = {1'b1, {(W_DEF-1){1'b0}}};
            r.ovf = 1'b1;
        end else begin
            r.val = {1'b0, {(W_DEF-1){1'b1}}};
            r.ovf = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cplx_alu_if.sv
// Operation request / completion bundle between the controller and cplx_alu.
interface cplx_alu_if;

    logic                         start;
    logic [2:0]                   opcode;
    logic [2*cplx_pkg::W_DEF-1:0] opA;
    logic [2*cplx_pkg::W_DEF-1:0] opB;
    logic [3:0]                   dest;
    logic [2*cplx_pkg::W_DEF-1:0] result;
    logic                         done;
    logic [3:0]                   wdest;
    logic                         ovf;
    logic                         busy;

    modport master (
        output start, opcode, opA, opB, dest,
        input  result, done, wdest, ovf, busy
    );

    modport slave (
        input  start, opcode, opA, opB, dest,
        output result, done, wdest, ovf, busy
    );

endinterface

// File: rtl/cplx_alu_sat.sv
// Clamps one wide signed field to W bits and reports whether clamping occurred.
module cplx_sat
    import cplx_pkg::*;
(
    input  logic signed [ACC_W-1:0] x_i,
    output logic        [W_DEF-1:0] val_o,
    output logic                    ovf_o
);

    sat_t s;

    always_comb begin
        s = sat_w(x_i);
    end

    assign val_o = s.val;
    assign ovf_o = s.ovf;

endmodule

// File: rtl/cplx_alu.sv
// Sequential complex fixed-point ALU: {re,im} operands, one shared 32x32 signed
// multiplier stepped through the products of MUL/MAG2, saturated registered result.
module cplx_alu
    import cplx_pkg::*;
#(
    parameter int unsigned FRAC = FRAC_DEF,
    parameter int unsigned W    = W_DEF
) (
    input  logic      clock,
    input  logic      reset,
    cplx_alu_if.slave bus
);

    localparam int unsigned AW = 2 * W + 2;

    logic [1:0]           state_q, state_d;
    logic [1:0]           k_q, k_d;
    logic [2:0]           op_q;
    logic [2*W-1:0]       a_q, b_q;
    logic [3:0]           dest_q;
    logic signed [AW-1:0] acc_re_q, acc_re_d;
    logic signed [AW-1:0] acc_im_q, acc_im_d;
    logic [2*W-1:0]       result_q;
    logic                 done_q;
    logic                 ovf_q;
    logic                 busy_q;
    logic [3:0]           wdest_q;
    logic                 accept;

    logic signed [W-1:0]    ar, ai, br, bi;
    logic signed [W-1:0]    mx, my;
    logic signed [2*W-1:0]  prod;
    logic signed [AW-1:0]   prod_x;
    logic signed [AW-1:0]   re_w, im_w;
    logic        [W-1:0]    re_s, im_s;
    logic                   re_ovf, im_ovf;

    assign ar = a_q[2*W-1:W];
    assign ai = a_q[W-1:0];
    assign br = b_q[2*W-1:W];
    assign bi = b_q[W-1:0];

    // The finishing cycle is not busy, so a new request can overlap the write-back.
    assign accept = bus.start && (state_q != ST_PROD);

    always_comb begin
        mx = ar;
        my = br;
        case (k_q)
            2'd0: begin mx = ar; my = (op_q == OP_MAG2) ? ar : br; end
            2'd1: begin mx = ai; my = (op_q == OP_MAG2) ? ai : bi; end
            2'd2: begin mx = ar; my = bi; end
            default: begin mx = ai; my = br; end
        endcase
    end

    assign prod   = (2*W)'(mx) * (2*W)'(my);
    assign prod_x = AW'(prod);

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        case (state_q)
            ST_PROD: begin
                k_d = k_q + 2'd1;
                if (op_q == OP_MAG2 || k_q == 2'd0) begin
                    acc_re_d = acc_re_q + prod_x;
                end else if (k_q == 2'd1) begin
                    acc_re_d = acc_re_q - prod_x;
                end else begin
                    acc_im_d = acc_im_q + prod_x;
                end
                if (k_q == 2'd3 || (op_q == OP_MAG2 && k_q == 2'd1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            k_d      = '0;
            acc_re_d = '0;
            acc_im_d = '0;
            state_d  = (bus.opcode == OP_MUL || bus.opcode == OP_MAG2) ? ST_PROD : ST_FIN;
        end
    end

    always_comb begin
        re_w = AW'(ar);
        im_w = AW'(ai);
        case (op_q)
            OP_ADD: begin
                re_w = AW'((W+1)'(ar) + (W+1)'(br));
                im_w = AW'((W+1)'(ai) + (W+1)'(bi));
            end
            OP_SUB: begin
                re_w = AW'((W+1)'(ar) - (W+1)'(br));
                im_w = AW'((W+1)'(ai) - (W+1)'(bi));
            end
            OP_MUL, OP_MAG2: begin
                re_w = acc_re_q >>> FRAC;
                im_w = acc_im_q >>> FRAC;
            end
            OP_CONJ: begin
                re_w = AW'(ar);
                im_w = AW'(-((W+1)'(ai)));
            end
            OP_NEG: begin
                re_w = AW'(-((W+1)'(ar)));
                im_w = AW'(-((W+1)'(ai)));
            end
            OP_SWAP: begin
                re_w = AW'(ai);
                im_w = AW'(ar);
            end
            default: begin
                re_w = AW'(ar);
                im_w = AW'(ai);
            end
        endcase
    end

    cplx_sat u_sat_re (
        .x_i   (re_w),
        .val_o (re_s),
        .ovf_o (re_ovf)
    );

    cplx_sat u_sat_im (
        .x_i   (im_w),
        .val_o (im_s),
        .ovf_o (im_ovf)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dest_q   <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            wdest_q  <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            busy_q   <= (state_d == ST_PROD);
            done_q   <= (state_q == ST_FIN);
            if (state_q == ST_FIN) begin
                result_q <= {re_s, im_s};
                ovf_q    <= re_ovf | im_ovf;
                wdest_q  <= dest_q;
            end
            if (accept) begin
                op_q   <= bus.opcode;
                a_q    <= bus.opA;
                b_q    <= bus.opB;
                dest_q <= bus.dest;
            end
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.wdest  = wdest_q;
    assign bus.ovf    = ovf_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_cplx_alu.sv
// Scoreboard bench for cplx_alu: wide-integer reference model, directed corner
// cases and randomized traffic including starts issued while busy.
module tb_cplx_alu;
    import cplx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cplx_alu_if bus ();

    cplx_alu #(.FRAC(16), .W(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic        ovf;
        logic [3:0]  dest;
        int unsigned at;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int unsigned cyc        = 0;
    int unsigned busy_until = 0;
    int          checks     = 0;
    int          failures   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] clamp32(input logic signed [127:0] v, output logic ov);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = 128'sd2147483647;
        lo = -128'sd2147483648;
        ov = 1'b0;
        if (v > hi) begin
            ov = 1'b1;
            return 32'h7FFFFFFF;
        end
        if (v < lo) begin
            ov = 1'b1;
            return 32'h80000000;
        end
        return v[31:0];
    endfunction

    function automatic void ref_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                   output logic [63:0] res, output logic ov, output int unsigned lat);
        logic signed [127:0] ar, ai, br, bi, re, im;
        logic o1, o2;
        ar  = 128'(signed'(a[63:32]));
        ai  = 128'(signed'(a[31:0]));
        br  = 128'(signed'(b[63:32]));
        bi  = 128'(signed'(b[31:0]));
        lat = 1;
        case (op)
            3'd0: begin re = ar + br; im = ai + bi; end
            3'd1: begin re = ar - br; im = ai - bi; end
            3'd2: begin
                re  = (ar * br - ai * bi) >>> 16;
                im  = (ar * bi + ai * br) >>> 16;
                lat = 5;
            end
            3'd3: begin re = ar;  im = -ai; end
            3'd4: begin re = -ar; im = -ai; end
            3'd5: begin
                re  = (ar * ar + ai * ai) >>> 16;
                im  = '0;
                lat = 3;
            end
            3'd6: begin re = ai; im = ar; end
            default: begin re = ar; im = ai; end
        endcase
        res[63:32] = clamp32(re, o1);
        res[31:0]  = clamp32(im, o2);
        ov = o1 | o2;
    endfunction

    function automatic logic [31:0] rnd_field();
        logic [31:0] s;
        case ($urandom_range(0, 4))
            0: s = 32'h80000000;
            1: s = 32'h7FFFFFFF;
            2: begin
                s = $urandom_range(0, 32'h0007FFFF);
                s = s - 32'h00040000;
            end
            default: s = $urandom;
        endcase
        return s;
    endfunction

    // One cycle of stimulus; the model decides acceptance from its own busy window.
    task automatic drive(input logic st, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [3:0] d);
        exp_t        e;
        logic [63:0] r;
        logic        o;
        int unsigned lat;
        bus.start  = st;
        bus.opcode = op;
        bus.opA    = a;
        bus.opB    = b;
        bus.dest   = d;
        if (st && !rst && cyc >= busy_until) begin
            ref_op(op, a, b, r, o, lat);
            e.res  = r;
            e.ovf  = o;
            e.dest = d;
            e.at   = cyc + 1 + lat;
            sbq.push_back(e);
            busy_until = cyc + lat;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 3'($urandom), {rnd_field(), rnd_field()}, {rnd_field(), rnd_field()}, 4'($urandom));
        end
    endtask

    task automatic do_reset(input int n);
        rst        = 1'b1;
        bus.start  = 1'b0;
        sbq.delete();
        busy_until = 0;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("busy", 64'(bus.busy), 64'(cyc < busy_until));
            if (sbq.size() > 0 && sbq[0].at == cyc) begin
                mon_e = sbq.pop_front();
                check("done", 64'(bus.done), 64'd1);
                check("result", bus.result, mon_e.res);
                check("ovf", 64'(bus.ovf), 64'(mon_e.ovf));
                check("wdest", 64'(bus.wdest), 64'(mon_e.dest));
            end else begin
                check("done_idle", 64'(bus.done), 64'd0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        bus.start  = 1'b0;
        bus.opcode = '0;
        bus.opA    = '0;
        bus.opB    = '0;
        bus.dest   = '0;
        @(negedge clk);
        #1;
        do_reset(2);
        check("rst_result", bus.result, 64'd0);
        check("rst_wdest", 64'(bus.wdest), 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);

        // MUL (1+j2)(3+j4), with a start two cycles in that must be ignored
        drive(1'b1, OP_MUL, 64'h00010000_00020000, 64'h00030000_00040000, 4'd5);
        drive(1'b0, OP_ADD, '0, '0, 4'd0);
        drive(1'b1, OP_ADD, 64'h11110000_22220000, 64'h33330000_44440000, 4'd9);
        idle(5);
        check("mul_res", bus.result, 64'hFFFB0000_000A0000);
        check("mul_ovf", 64'(bus.ovf), 64'd0);
        check("mul_wdest", 64'(bus.wdest), 64'd5);

        drive(1'b1, OP_ADD, 64'h7FFFFFFF_00000001, 64'h00000001_00000001, 4'd1);
        idle(2);
        check("addsat_res", bus.result, 64'h7FFFFFFF_00000002);
        check("addsat_ovf", 64'(bus.ovf), 64'd1);

        drive(1'b1, OP_MAG2, 64'h00030000_00040000, 64'h12345678_9ABCDEF0, 4'd2);
        idle(4);
        check("mag2_res", bus.result, 64'h00190000_00000000);

        drive(1'b1, OP_NEG, 64'h80000000_00010000, 64'h0, 4'd3);
        idle(2);
        check("neg_res", bus.result, 64'h7FFFFFFF_FFFF0000);
        check("neg_ovf", 64'(bus.ovf), 64'd1);
        drive(1'b1, OP_SWAP, 64'h80000000_00010000, 64'h0, 4'd4);
        idle(2);
        check("swap_res", bus.result, 64'h00010000_80000000);
        check("swap_ovf", 64'(bus.ovf), 64'd0);

        // Start presented exactly in the MUL done cycle
        drive(1'b1, OP_MUL, 64'h00020000_FFFF0000, 64'h00008000_00030000, 4'd7);
        idle(5);
        drive(1'b1, OP_ADD, 64'h00010000_00010000, 64'h00010000_00010000, 4'd8);
        idle(2);
        check("b2b_res", bus.result, 64'h00020000_00020000);
        check("b2b_wdest", 64'(bus.wdest), 64'd8);

        // Reset in the third MUL cycle discards the operation
        drive(1'b1, OP_MUL, 64'h00010000_00020000, 64'h00030000_00040000, 4'd6);
        idle(2);
        do_reset(1);
        check("midrst_result", bus.result, 64'd0);
        check("midrst_wdest", 64'(bus.wdest), 64'd0);
        check("midrst_ovf", 64'(bus.ovf), 64'd0);
        idle(6);
        drive(1'b1, OP_ADD, 64'h00000001_00000001, 64'h00000001_00000001, 4'd10);
        idle(2);
        check("postrst_add", bus.result, 64'h00000002_00000002);

        for (int i = 0; i < 400; i++) begin
            drive(1'b1, 3'($urandom), {rnd_field(), rnd_field()}, {rnd_field(), rnd_field()}, 4'($urandom));
            idle(int'($urandom_range(0, 6)));
        end

        for (int i = 0; i < 20 && sbq.size() > 0; i++) idle(1);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d completions pending, expected 0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
